// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter
//  Brief    : Handshaked ALU with single-cycle base ops and iterative
//             radix-2 unsigned multiply / restoring divide.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             Zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SLTU = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_NOR  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_operand;
    logic [1:0]         r_mdSel;
    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic               r_carry;
    logic               r_zero;

    logic               w_mdEn;
    logic               w_startMd;
    logic               w_isSub;
    logic [WIDTH-1:0]   w_bOp;
    logic [WIDTH:0]     w_sum;
    logic               w_cout;
    logic               w_cinMsb;
    logic               w_ovf;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_aluResult;
    logic               w_aluOvf;
    logic               w_aluCarry;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divDiff;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_stepNext;
    logic [WIDTH-1:0]   w_mdResult;

    generate
        if (MD_EN) begin : g_mdOn
            assign w_mdEn = 1'b1;
        end else begin : g_mdOff
            assign w_mdEn = 1'b0;
        end
    endgenerate

    assign w_startMd = w_mdEn && (ALUop[3:2] == 2'b10);

    // Shared adder: subtraction as A + ~B + 1
    always_comb begin
        w_isSub  = (ALUop == c_OP_SUB) || (ALUop == c_OP_SLT) || (ALUop == c_OP_SLTU);
        w_bOp    = w_isSub ? ~B : B;
        w_sum    = {1'b0, A} + {1'b0, w_bOp} + {{WIDTH{1'b0}}, w_isSub};
        w_cout   = w_sum[WIDTH];
        w_cinMsb = A[WIDTH-1] ^ w_bOp[WIDTH-1] ^ w_sum[WIDTH-1];
        w_ovf    = w_cinMsb ^ w_cout;
        w_borrow = ~w_cout;
    end

    always_comb begin
        w_aluResult = '0;
        w_aluOvf    = 1'b0;
        w_aluCarry  = 1'b0;
        case (ALUop)
            c_OP_AND:  w_aluResult = A & B;
            c_OP_OR:   w_aluResult = A | B;
            c_OP_ADD: begin
                w_aluResult = w_sum[WIDTH-1:0];
                w_aluOvf    = w_ovf;
                w_aluCarry  = w_cout;
            end
            c_OP_SLTU: begin
                w_aluResult = {{(WIDTH-1){1'b0}}, w_borrow};
                w_aluCarry  = w_borrow;
            end
            c_OP_XOR:  w_aluResult = A ^ B;
            c_OP_NOR:  w_aluResult = ~(A | B);
            c_OP_SUB: begin
                w_aluResult = w_sum[WIDTH-1:0];
                w_aluOvf    = w_ovf;
                w_aluCarry  = w_borrow;
            end
            c_OP_SLT: begin
                w_aluResult = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
                w_aluOvf    = w_ovf;
            end
            default: w_aluResult = '0;
        endcase
    end

    // One iteration step; r_work holds {upper, lower} for both mul and div
    always_comb begin
        w_mulSum   = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_operand} : '0);
        w_mulNext  = {w_mulSum, r_work[WIDTH-1:1]};
        w_divDiff  = r_work[2*WIDTH-1:WIDTH-1] - {1'b0, r_operand};
        w_divNext  = w_divDiff[WIDTH] ? {r_work[2*WIDTH-2:0], 1'b0}
                                      : {w_divDiff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};
        w_stepNext = r_mdSel[1] ? w_divNext : w_mulNext;
        w_mdResult = r_mdSel[0] ? w_stepNext[2*WIDTH-1:WIDTH] : w_stepNext[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_work     <= '0;
            r_operand  <= '0;
            r_mdSel    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_mdSel <= ALUop[1:0];
                        if (w_startMd) begin
                            r_count <= CW'(WIDTH);
                            r_state <= c_BUSY;
                            if (ALUop[1]) begin
                                r_work    <= {{WIDTH{1'b0}}, A};
                                r_operand <= B;
                            end else begin
                                r_work    <= {{WIDTH{1'b0}}, B};
                                r_operand <= A;
                            end
                        end else begin
                            r_result   <= w_aluResult;
                            r_overflow <= w_aluOvf;
                            r_carry    <= w_aluCarry;
                            r_zero     <= (w_aluResult == '0);
                            r_state    <= c_DONE;
                        end
                    end
                end
                c_BUSY: begin
                    r_work  <= w_stepNext;
                    r_count <= r_count - 1'b1;
                    if (r_count == CW'(1)) begin
                        r_result   <= w_mdResult;
                        r_overflow <= 1'b0;
                        r_carry    <= 1'b0;
                        r_zero     <= (w_mdResult == '0);
                        r_state    <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign Result    = r_result;
    assign Overflow  = r_overflow;
    assign CarryOut  = r_carry;
    assign Zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iter
//  Brief    : Self-checking bench for alu_iter (WIDTH=32, MD_EN=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Overflow;
    logic        CarryOut;
    logic        Zero;

    int errCount   = 0;
    int checkCount = 0;

    alu_iter #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Overflow  (Overflow),
        .CarryOut  (CarryOut),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model from arithmetic definitions of each op
    task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic ovf, output logic cy);
        logic [32:0] s;
        logic [31:0] d;
        logic [63:0] p;
        res = '0; ovf = 1'b0; cy = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        d = a - b;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0: res = a & b;
            4'd1: res = a | b;
            4'd2: begin res = s[31:0]; cy = s[32]; ovf = (a[31] == b[31]) && (res[31] != a[31]); end
            4'd3: begin res = (a < b) ? 32'd1 : 32'd0; cy = (a < b); end
            4'd4: res = a ^ b;
            4'd5: res = ~(a | b);
            4'd6: begin res = d; cy = (a < b); ovf = (a[31] != b[31]) && (d[31] != a[31]); end
            4'd7: begin
                res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ovf = (a[31] != b[31]) && (d[31] != a[31]);
            end
            4'd8:  res = p[31:0];
            4'd9:  res = p[63:32];
            4'd10: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd11: res = (b == 0) ? a : a % b;
            default: res = '0;
        endcase
    endtask

    task automatic startOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        checkValue($sformatf("op%0d in_ready before accept", op), in_ready, 1);
        in_valid = 1'b1; A = a; B = b; ALUop = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; ALUop = 4'($urandom);
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) checkValue("out_valid timeout", 0, 1);
    endtask

    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] eRes;
        logic        eOvf;
        logic        eCy;
        int          lat;
        refModel(op, a, b, eRes, eOvf, eCy);
        startOp(op, a, b);
        waitValid(lat);
        checkValue($sformatf("op%0d latency", op), lat, (op >= 4'd8 && op <= 4'd11) ? 33 : 1);
        checkValue($sformatf("op%0d %h,%h result", op, a, b), Result, eRes);
        checkValue($sformatf("op%0d overflow", op), Overflow, eOvf);
        checkValue($sformatf("op%0d carry", op), CarryOut, eCy);
        checkValue($sformatf("op%0d zero", op), Zero, eRes == 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkValue($sformatf("op%0d stall result", op), Result, eRes);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 2))
            0:       return corners[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        bit sawValid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALUop = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkValue("reset in_ready", in_ready, 1);
        checkValue("reset out_valid", out_valid, 0);
        checkValue("reset result", Result, 0);
        checkValue("reset flags", {Overflow, CarryOut, Zero}, 0);
        rst = 1'b0;

        runOp(4'd2, 32'h7FFF_FFFF, 32'h1, 0);
        runOp(4'd6, 32'd5, 32'd5, 0);
        runOp(4'd7, 32'hFFFF_FFFF, 32'd1, 0);
        runOp(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
        runOp(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        runOp(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        runOp(4'd10, 32'd100, 32'd7, 0);
        runOp(4'd11, 32'd100, 32'd7, 0);
        runOp(4'd10, 32'd9, 32'd0, 0);
        runOp(4'd11, 32'd9, 32'd0, 0);
        runOp(4'd12, 32'd9, 32'd3, 0);

        // Backpressure: DONE holds, and requests made during DONE are dropped
        startOp(4'd6, 32'd50, 32'd8);
        waitValid(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; ALUop = 4'd2; A = $urandom; B = $urandom;
            @(negedge clk);
            checkValue("bp result hold", Result, 42);
            checkValue("bp in_ready low", in_ready, 0);
            checkValue("bp out_valid held", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkValue("bp no queued op", out_valid, 0);
        end

        // Reset mid-divide aborts the operation
        runOp(4'd2, 32'd20, 32'd22, 0);
        startOp(4'd10, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkValue("abort in_ready", in_ready, 1);
        checkValue("abort out_valid", out_valid, 0);
        checkValue("abort result", Result, 0);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkValue("abort no out_valid", sawValid, 0);
        runOp(4'd2, 32'd1234, 32'd4321, 0);

        for (int n = 0; n < 40; n++) begin
            runOp(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
